flex_sr_deser: RTL

Parametrised serial-to-parallel deserializer, the next generation of the team's flexible serial-to-parallel shift register. Adds a selectable shift direction, a bit counter that frames NUM_BITS-bit words, a registered word output with a valid/ready handshake, and a sticky overrun flag. Sits between a serial receive front end and the word-wide datapath of the AES chip, such as key or state loading.

---
 rtl/flex_sr_deser.sv | 90 +++++++++
 1 files changed

// File: rtl/flex_sr_deser.sv
// Serial-to-parallel deserializer: frames NUM_BITS-bit words from a bit stream
// and presents each completed word on a valid/ready port with a sticky overrun flag.
module flex_sr_deser #(
  parameter int NUM_BITS  = 8,
  parameter int SHIFT_MSB = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        shift_enable,
  input  logic                        serial_in,
  input  logic                        word_ready,
  output logic [NUM_BITS-1:0]         parallel_out,
  output logic [NUM_BITS-1:0]         word_out,
  output logic                        word_valid,
  output logic [$clog2(NUM_BITS)-1:0] bit_count,
  output logic                        overrun
);

  localparam int             CW   = $clog2(NUM_BITS);
  localparam logic [CW-1:0]  LAST = CW'(NUM_BITS - 1);

  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [NUM_BITS-1:0] word_q, word_d;
  logic [CW-1:0]       count_q, count_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic [NUM_BITS-1:0] shift_val;
  logic                complete;

  always_comb begin
    if (SHIFT_MSB != 0) shift_val = {shift_q[NUM_BITS-2:0], serial_in};
    else                shift_val = {serial_in, shift_q[NUM_BITS-1:1]};
  end

  assign complete = shift_enable && (count_q == LAST);

  always_comb begin
    shift_d   = shift_q;
    count_d   = count_q;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (clear) begin
      // word_out deliberately survives a soft clear
      shift_d   = '0;
      count_d   = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (shift_enable) begin
        shift_d = shift_val;
        count_d = complete ? '0 : count_q + CW'(1);
      end
      if (complete) begin
        if (!valid_q || word_ready) begin
          word_d  = shift_val;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else if (valid_q && word_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      count_q   <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      count_q   <= count_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign parallel_out = shift_q;
  assign word_out     = word_q;
  assign word_valid   = valid_q;
  assign bit_count    = count_q;
  assign overrun      = overrun_q;

endmodule
